// File: rtl/instr_issue_queue.sv
// instr_issue_queue: circular instruction FIFO feeding a registered issue port.
// Each pop presents the head entry for one cycle and increments the issue
// counter. A cycle without a pop presents a NOP (32'h0).
// Optional feature: define IFQ_ILLEGAL_FILTER_EN to drop writes whose opcode
// (bits [5:0]) is not legal, and to count those drops in illegal_cnt.
// Reset asserts asynchronously and releases through a two-flop synchronizer.
// The edge that first samples rst_n high is the release edge. The first write
// is accepted on the second edge after it.
module instr_issue_queue #(
   parameter int DEPTH = 8,
   parameter int PC_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [31:0]              wr_instr,
   input  logic                     stall,
   input  logic                     flush,
   output logic [31:0]              instruction,
   output logic                     issue_valid,
   output logic [PC_W-1:0]          pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic [7:0]               illegal_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [1:0]      rst_sync_q;
   logic            active;
   logic [31:0]     mem_q [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     instr_q, instr_d;
   logic            valid_q, valid_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            opc_legal, pop, wr_try, push;

   // Reset synchronizer: clears immediately, releases two edges later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign active = rst_sync_q[1];

   // Occupancy decodes straight from the registered count
   assign count = count_q;
   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

`ifdef IFQ_ILLEGAL_FILTER_EN
   logic [7:0] ill_q;

   // Opcode legality check on the incoming write
   always_comb begin
      opc_legal = 1'b0;
      case (wr_instr[5:0])
         6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
         6'h07, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: opc_legal = 1'b1;
         default:                                  opc_legal = 1'b0;
      endcase
   end

   // Saturating count of filtered writes; a write already lost to full is not counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                ill_q <= 8'h00;
      else if (!active)                          ill_q <= 8'h00;
      else if (wr_try && !opc_legal && ill_q != 8'hFF) ill_q <= ill_q + 8'h01;
   end

   assign illegal_cnt = ill_q;
`else
   assign opc_legal   = 1'b1;
   assign illegal_cnt = 8'h00;
`endif

   // Pop and write qualification; a full queue still takes a write when it pops on the same edge
   assign pop    = active & ~stall & ~flush & ~empty;
   assign wr_try = active & wr_en & ~flush & (~full | pop);
   assign push   = wr_try & opc_legal;

   // Next-state for pointers, occupancy and the issue port
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      instr_d  = 32'h0;
      valid_d  = 1'b0;
      pc_d     = pc_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            instr_d  = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
            pc_d     = pc_q + PC_W'(1);
         end
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control and issue registers; held clear until the synchronizer releases
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || !active) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         instr_q  <= 32'h0;
         valid_q  <= 1'b0;
         pc_q     <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         pc_q     <= pc_d;
      end
   end

   // Queue storage, no reset; the head is read from the old value, so there is no bypass
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_instr;
   end

   assign instruction = instr_q;
   assign issue_valid = valid_q;
   assign pc          = pc_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue with a queue scoreboard of expected issues.
module tb_instr_issue_queue;

   localparam int DEPTH = 8;
   localparam int PC_W  = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_instr = 32'h0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] instruction;
   logic        issue_valid;
   logic [PC_W-1:0] pc;
   logic [3:0]  count;
   logic        full, empty;
   logic [7:0]  illegal_cnt;

   int errors = 0;
   int checks = 0;

   logic [31:0] sb[$];
   logic [31:0] e_instr = 32'h0;
   logic        e_vld = 1'b0;
   logic [7:0]  e_pc = 8'h0;
   logic [7:0]  e_ill = 8'h0;

   instr_issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_instr(wr_instr),
      .stall(stall), .flush(flush), .instruction(instruction),
      .issue_valid(issue_valid), .pc(pc), .count(count), .full(full),
      .empty(empty), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [31:0] ins);
`ifdef IFQ_ILLEGAL_FILTER_EN
      case (ins[5:0])
         6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
         6'h07, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return 1'b1;
         default: return 1'b0;
      endcase
`else
      return 1'b1;
`endif
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".instr"}, instruction, e_instr);
      chk({tag, ".valid"}, {31'h0, issue_valid}, {31'h0, e_vld});
      chk({tag, ".pc"}, {24'h0, pc}, {24'h0, e_pc});
      chk({tag, ".count"}, {28'h0, count}, 32'(sb.size()));
      chk({tag, ".full"}, {31'h0, full}, {31'h0, (sb.size() == DEPTH)});
      chk({tag, ".empty"}, {31'h0, empty}, {31'h0, (sb.size() == 0)});
      chk({tag, ".ill"}, {24'h0, illegal_cnt}, {24'h0, e_ill});
   endtask

   // One clock edge: model predicts the outcome of the driven inputs, then compare
   task automatic tick(input string tag);
      int  sz;
      bit  pop_m, acc, lg;
      sz    = sb.size();
      lg    = legal(wr_instr);
      pop_m = !stall && !flush && (sz > 0);
      acc   = wr_en && !flush && ((sz < DEPTH) || pop_m);
      if (flush) begin
         sb.delete(); e_instr = 32'h0; e_vld = 1'b0;
      end else if (pop_m) begin
         e_instr = sb.pop_front(); e_vld = 1'b1; e_pc = e_pc + 8'h1;
      end else begin
         e_instr = 32'h0; e_vld = 1'b0;
      end
      if (acc && lg) sb.push_back(wr_instr);
      if (acc && !lg && e_ill != 8'hFF) e_ill = e_ill + 8'h1;
      @(posedge clk); #1;
      check_all(tag);
   endtask

   task automatic idle();
      wr_en = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      // Asynchronous reset, observed before any clock edge
      #3 rst_n = 1'b0;
      #1 check_all("reset_async");
      @(posedge clk); #1 check_all("reset_held");
      rst_n = 1'b1;
      tick("sync0");
      tick("sync1");

      // Single write, issued one edge later
      wr_en = 1'b1; wr_instr = 32'h0000_0845;
      tick("w1");
      chk("w1.not_bypassed", {31'h0, issue_valid}, 32'h0);
      idle();
      tick("w1_issue");
      chk("w1.instr_const", instruction, 32'h0000_0845);

      // Fill under stall, ninth write dropped, then drain in order
      stall = 1'b1; wr_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wr_instr = 32'h1000_0005 | (32'(i) << 8);
         tick("fill");
      end
      chk("fill.full", {31'h0, full}, 32'h1);
      wr_en = 1'b0; stall = 1'b0;
      for (int i = 0; i < 8; i++) tick("drain");
      chk("drain.pc", {24'h0, pc}, 32'd9);

      // Full queue with write and pop on the same edge
      stall = 1'b1; wr_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_instr = 32'h2000_0003 | (32'(i) << 8);
         tick("fill2");
      end
      stall = 1'b0; wr_instr = 32'h2000_AA0C;
      tick("wr_pop_full");
      wr_en = 1'b0;
      for (int i = 0; i < 8; i++) tick("drain2");
      chk("drain2.last", instruction, 32'h2000_AA0C);

      // Flush with a pending write
      stall = 1'b1; wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_instr = 32'h3000_0002 | (32'(i) << 8);
         tick("fill3");
      end
      flush = 1'b1; wr_instr = 32'h3000_FF02;
      tick("flush");
      idle();
      tick("post_flush");

      // Opcode filter: 0x09 then 0x05
      wr_en = 1'b1; wr_instr = 32'h4000_0009;
      tick("op09");
      wr_instr = 32'h4000_0005;
      tick("op05");
      idle();
      tick("op_d1");
      tick("op_d2");
      tick("op_d3");

      // Streaming write+issue through a pc wrap
      wr_en = 1'b1;
      for (int i = 0; i < 260; i++) begin
         wr_instr = 32'h5000_0004 | (32'(i) << 8);
         tick("stream");
      end

      // Reset mid-burst with entries queued
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_instr = 32'h6000_0006 | (32'(i) << 8);
         tick("pre_rst");
      end
      stall = 1'b0;
      tick("burst");
      #2 rst_n = 1'b0;
      sb.delete(); e_instr = 32'h0; e_vld = 1'b0; e_pc = 8'h0; e_ill = 8'h0;
      #1 check_all("rst_mid");
      idle();
      @(posedge clk); #1 check_all("rst_mid_held");
      rst_n = 1'b1;
      tick("resync0");
      tick("resync1");
      tick("no_stale");
      wr_en = 1'b1; wr_instr = 32'h7000_000F;
      tick("after_rst_w");
      idle();
      tick("after_rst_issue");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_issue_queue.md
INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, 2..64.
REQ-002 Parameter PC_W, default 8, issue-counter width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 wr_en  in  1  loader write strobe.
REQ-006 wr_instr  in  32  instruction to enqueue; bits [5:0] are the opcode.
REQ-007 stall  in  1  downstream hold; no issue while high.
REQ-008 flush  in  1  synchronous queue clear.
REQ-009 instruction  out  32  registered instruction presented to the execute stage.
REQ-010 issue_valid  out  1  high when instruction holds a dequeued entry.
REQ-011 pc  out  PC_W  count of issued instructions.
REQ-012 count  out  log2(DEPTH)+1  current occupancy.
REQ-013 full  out  1  count equals DEPTH.
REQ-014 empty  out  1  count equals 0.
REQ-015 illegal_cnt  out  8  number of filtered writes (see Configuration).

Function
REQ-016 The block SHALL be a circular FIFO with separate read and write pointers that wrap from DEPTH-1 to 0.
REQ-017 A pop SHALL occur on a clock edge iff !stall, !flush, and !empty.
REQ-018 On a pop, instruction SHALL load the head entry, issue_valid SHALL be 1, and pc SHALL increment by 1, wrapping from all-ones to 0.
REQ-019 Without a pop, instruction SHALL load 32'h0 (opcode 0, a one-cycle NOP), issue_valid SHALL be 0, and pc SHALL hold.
REQ-020 A write SHALL be accepted iff wr_en is high, flush is low, and either !full or a pop occurs on the same edge.
REQ-021 A write attempted while full with no same-edge pop SHALL be dropped, leaving contents and count unchanged.
REQ-022 There SHALL be no bypass path: an instruction written at edge N SHALL be issued no earlier than edge N+1.
REQ-023 Simultaneous accepted write and pop SHALL leave count unchanged.
REQ-024 flush SHALL zero both pointers and count, drive instruction to 32'h0 and issue_valid to 0, hold pc, and override wr_en and the pop.
REQ-025 full, empty, and count SHALL be combinational decodes of the registered occupancy.

Reset
REQ-026 While rst_n is low, the block SHALL clear pointers, count, pc, and illegal_cnt, and drive instruction to 32'h0 and issue_valid to 0, independent of clk.
REQ-027 Reset SHALL be asserted asynchronously and deasserted synchronously (two-flop synchronizer inside the block); the first write is accepted on the second edge after release.
REQ-028 Reset mid-stream SHALL discard queued entries; no partial instruction SHALL be issued afterward.
REQ-029 Queue storage need not be reset.

Configuration
REQ-030 Macro IFQ_ILLEGAL_FILTER_EN, when defined, SHALL discard writes whose opcode is not one of 0x0, 0x2, 0x3, 0x4, 0x5, 0x6, 0x7, 0x8, 0xA, 0xC, 0xD, 0xF, and increment illegal_cnt, saturating at 255.
REQ-031 A filtered write SHALL not change count and SHALL not be counted when dropped for full.
REQ-032 With IFQ_ILLEGAL_FILTER_EN undefined, all writes SHALL be enqueued regardless of opcode, and illegal_cnt SHALL be tied to 0.

Verification
REQ-033 Reset, then write 0x00000845 on edge 1 with stall=0 -> after edge 2: instruction=0x00000845, issue_valid=1, pc=1, empty=1.
REQ-034 Stall=1, write 8 entries (DEPTH=8), then a 9th -> full=1, count=8, 9th dropped; release stall -> 8 issues in order on consecutive edges, pc=8.
REQ-035 Full queue, wr_en and pop on the same edge -> write accepted, count stays 8; the new entry is issued 8 edges later.
REQ-036 Queue holding 3 entries, flush=1 with wr_en=1 -> count=0, empty=1, instruction=0, pc unchanged, write ignored.
REQ-037 With IFQ_ILLEGAL_FILTER_EN defined, write opcode 0x09 then 0x05 -> only 0x05 issued, illegal_cnt=1; undefined -> both issued, illegal_cnt=0.
REQ-038 Issue 256 instructions (PC_W=8) -> pc wraps 255->0; assert rst_n low mid-burst -> all outputs zero immediately, without a clk edge.
